// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding a UART transmitter: one load strobe per byte, then wait for
// the transmitter's end-of-frame pulse before issuing the next one.
module uart_tx_fifo #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [7:0]        wr_data,
  input  logic              flush,
  input  logic              clr_ovf,
  input  logic              uart_tx_ready,
  output logic              uart_tx_req,
  output logic [7:0]        uart_tx_data,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              busy
);

  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                req_q, req_d;
  logic [7:0]          data_q, data_d;
  logic                ovf_q, ovf_d;
  logic                full_q, full_d;
  logic                empty_q, empty_d;
  logic                busy_q, busy_d;
  logic [7:0]          mem_q [DEPTH];

  logic                wr_acc;
  logic                wr_drop;
  logic                pop;

  // Next-state, pop decision and bookkeeping; full is judged on the pre-pop count.
  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    req_d    = 1'b0;
    data_d   = data_q;
    ovf_d    = ovf_q;
    pop      = 1'b0;
    wr_acc   = wr_en && !flush && (count_q != CNT_FULL);
    wr_drop  = wr_en && !flush && (count_q == CNT_FULL);

    case (state_q)
      S_IDLE: begin
        if ((count_q != '0) && !flush) begin
          pop     = 1'b1;
          req_d   = 1'b1;
          data_d  = mem_q[rd_ptr_q];
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (uart_tx_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      ovf_d    = 1'b0;
    end else begin
      if (wr_acc) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
      if (pop)    rd_ptr_d = rd_ptr_q + ADDR_W'(1);
      case ({wr_acc, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
      if (wr_drop)      ovf_d = 1'b1;
      else if (clr_ovf) ovf_d = 1'b0;
    end

    full_d  = (count_d == CNT_FULL);
    empty_d = (count_d == '0);
    busy_d  = (state_d == S_WAIT) || (count_d != '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      req_q    <= 1'b0;
      data_q   <= 8'h00;
      ovf_q    <= 1'b0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      req_q    <= req_d;
      data_q   <= data_d;
      ovf_q    <= ovf_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      busy_q   <= busy_d;
    end
  end

  // Storage array carries no reset.
  always_ff @(posedge clk) begin
    if (wr_acc && !reset) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  assign uart_tx_req  = req_q;
  assign uart_tx_data = data_q;
  assign full         = full_q;
  assign empty        = empty_q;
  assign count        = count_q;
  assign overflow     = ovf_q;
  assign busy         = busy_q;

endmodule
